// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the data-memory port arbiter.
//   The state encodings double as the arb_owner debug code
//   (00 idle, 01 CPU, 10 DMA), so the debug/CSR path can reuse them.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_CPU  = 2'b01,
        ARB_DMA  = 2'b10
    } arb_state_t;

    localparam int ARB_XLEN_DEF   = 32;
    localparam int ARB_ADDR_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-memory port between the CPU load/store unit and
//   the DMA master port. The CPU normally wins contention. After
//   DMA_STARVE_MAX lost contended arbitrations, the DMA is forced to win the
//   next contended one. Every grant is followed by one IDLE bubble.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   cpu_mem_req/we/addr/wdata          CPU request, held until cpu_mem_ready
//   cpu_mem_rdata, cpu_mem_ready       CPU response (rdata valid with ready)
//   dma_mem_req/we/addr/wdata          DMA request, held until dma_mem_ready
//   dma_mem_rdata, dma_mem_ready       DMA response (rdata valid with ready)
//   mem_req/we/addr/wdata              downstream request
//   mem_rdata, mem_ready               downstream response
//   arb_owner                          debug: 00 idle, 01 CPU, 10 DMA
//
// state    | meaning
// ---------+-----------------------------------------------
// ARB_IDLE | arbitration cycle, nothing forwarded
// ARB_CPU  | CPU transaction in flight, CPU forwarded
// ARB_DMA  | DMA transaction in flight, DMA forwarded
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN           = ARB_XLEN_DEF,
    parameter int ADDR_W         = ARB_ADDR_W_DEF,
    parameter int DMA_STARVE_MAX = 4,
    parameter int STARVE_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_mem_req,
    input  logic              cpu_mem_we,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [XLEN-1:0]   cpu_mem_wdata,
    output logic [XLEN-1:0]   cpu_mem_rdata,
    output logic              cpu_mem_ready,

    input  logic              dma_mem_req,
    input  logic              dma_mem_we,
    input  logic [ADDR_W-1:0] dma_mem_addr,
    input  logic [XLEN-1:0]   dma_mem_wdata,
    output logic [XLEN-1:0]   dma_mem_rdata,
    output logic              dma_mem_ready,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,

    output logic [1:0]        arb_owner
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(DMA_STARVE_MAX);

    arb_state_t          state;
    logic [STARVE_W-1:0] starve_cnt;

    // Decision is made in IDLE and takes effect next cycle. A busy owner
    // dropping req is ignored: only mem_ready ends the transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (cpu_mem_req && dma_mem_req) begin
                        if (starve_cnt == STARVE_MAX) begin
                            state      <= ARB_DMA;
                            starve_cnt <= '0;
                        end else begin
                            state <= ARB_CPU;
                            if (starve_cnt < STARVE_MAX)
                                starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (cpu_mem_req) begin
                        state <= ARB_CPU;
                    end else if (dma_mem_req) begin
                        state      <= ARB_DMA;
                        starve_cnt <= '0;
                    end
                end
                ARB_CPU, ARB_DMA: begin
                    if (mem_ready)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // The state register is the owner code, so arb_owner is registered.
    assign arb_owner = state;

    // Read data is broadcast; each requester qualifies it with its ready.
    assign cpu_mem_rdata = mem_rdata;
    assign dma_mem_rdata = mem_rdata;

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        cpu_mem_ready = 1'b0;
        dma_mem_ready = 1'b0;
        case (state)
            ARB_CPU: begin
                mem_req       = 1'b1;
                mem_we        = cpu_mem_we;
                mem_addr      = cpu_mem_addr;
                mem_wdata     = cpu_mem_wdata;
                cpu_mem_ready = mem_ready;
            end
            ARB_DMA: begin
                mem_req       = 1'b1;
                mem_we        = dma_mem_we;
                mem_addr      = dma_mem_addr;
                mem_wdata     = dma_mem_wdata;
                dma_mem_ready = mem_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single data-memory port between the CPU load/store unit and the DMA engine's master port. Two requesters speak the codebase's memory request/response protocol: req/we/addr/wdata are held stable until ready, and ready is a one-cycle completion pulse with rdata valid the same cycle. The arbiter serialises them onto one downstream port. CPU has priority by default, with a starvation guard so DMA copies always progress. It sits between core/dma_engine and the data RAM/bus fabric.

Parameters:
XLEN, 32, data width (from defines.vh)
ADDR_W, 32, address width (from defines.vh)
DMA_STARVE_MAX, 4, lost arbitrations after which DMA is forced to win; legal range 1..15
STARVE_W, 4, width of the starvation counter; must hold DMA_STARVE_MAX

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
cpu_mem_req  input  1  CPU request, held until cpu_mem_ready
cpu_mem_we  input  1  CPU write enable
cpu_mem_addr  input  ADDR_W  CPU address
cpu_mem_wdata  input  XLEN  CPU write data
cpu_mem_rdata  output  XLEN  read data, valid when cpu_mem_ready
cpu_mem_ready  output  1  CPU completion pulse
dma_mem_req  input  1  DMA request, held until dma_mem_ready
dma_mem_we  input  1  DMA write enable
dma_mem_addr  input  ADDR_W  DMA address
dma_mem_wdata  input  XLEN  DMA write data
dma_mem_rdata  output  XLEN  read data, valid when dma_mem_ready
dma_mem_ready  output  1  DMA completion pulse
mem_req  output  1  downstream request
mem_we  output  1  downstream write enable
mem_addr  output  ADDR_W  downstream address
mem_wdata  output  XLEN  downstream write data
mem_rdata  input  XLEN  downstream read data
mem_ready  input  1  downstream completion pulse
arb_owner  output  2  debug: 00 idle, 01 CPU, 10 DMA

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- States:
  - IDLE: arbitration cycle.
  - BUSY_CPU: CPU transaction in flight.
  - BUSY_DMA: DMA transaction in flight.
- Reset: state=IDLE, starve_cnt=0. mem_req, cpu_mem_ready, dma_mem_ready=0. mem_we/addr/wdata=0. arb_owner=00.
- IDLE arbitration, registered decision, taking effect next cycle:
  - no req: stay IDLE.
  - cpu only: go BUSY_CPU.
  - dma only: go BUSY_DMA, starve_cnt<=0.
  - both, starve_cnt==DMA_STARVE_MAX: go BUSY_DMA, starve_cnt<=0.
  - both, otherwise: go BUSY_CPU, starve_cnt<=starve_cnt+1, saturating at DMA_STARVE_MAX.
- BUSY_x, combinational forwarding:
  - mem_req=1; mem_we/addr/wdata come from owner x.
  - x_mem_ready=mem_ready; the other requester's ready=0.
  - mem_rdata is broadcast to both rdata outputs; it is qualified only by ready.
- BUSY_x completion: on mem_ready=1, next state=IDLE. There is always one IDLE bubble between grants.
  - Minimum latency, request to ready: 2 cycles. Req sampled in IDLE at T0; BUSY at T1; mem_ready at T1 gives ready at T1.
- While BUSY, a deasserting owner req is a protocol violation. The arbiter ignores it, keeps forwarding, and stays BUSY until mem_ready.
- mem_ready arriving in IDLE is ignored; no ready is routed.
- Outside BUSY: mem_we/addr/wdata=0.
- A request arriving during BUSY waits; it is evaluated at the next IDLE.
- After ready the requester may hold req high for a new transaction. The IDLE cycle samples it as fresh.
- Guarantees:
  - DMA wins at most 1 of every DMA_STARVE_MAX+1 contended grants. CPU waits at most one DMA transaction plus one bubble.
  - DMA waits at most DMA_STARVE_MAX CPU transactions.
- arb_owner is a registered copy of the state encoding.
- rst_n asserted mid-transaction: immediately IDLE, all outputs at reset values; the in-flight access is abandoned. After release, arbitration restarts fresh with starve_cnt=0.

Decomposition:
- defines.vh: XLEN and ADDR_W. Add ARB_IDLE/ARB_CPU/ARB_DMA 2-bit encodings there; the debug/CSR path reuses them.
- Port groups use the existing MEM_REQ/MEM_RSP port macros in interface.vh.
- No sub-module. The FSM, starvation counter and output mux live in one module.

Test Plan:
- Reset: rst_n=0 with both reqs high -> mem_req=0, both readies=0, arb_owner=00. After release, first grant goes to CPU.
- CPU-only read addr=0x100, memory returns 0xDEADBEEF with ready one cycle after mem_req -> cpu_mem_ready for 1 cycle with rdata=0xDEADBEEF; dma_mem_ready stays 0.
- Both requesting continuously, DMA_STARVE_MAX=4 -> grant sequence CPU,CPU,CPU,CPU,DMA repeating; IDLE bubble between each grant.
- DMA write addr=0x2000 wdata=0x5A5A5A5A while memory stalls ready 3 cycles; CPU requests mid-stall -> mem_addr/wdata stay DMA values until ready. CPU is granted at the next IDLE.
- Spurious mem_ready in IDLE, and owner dropping req mid-transaction -> no ready routed in IDLE; FSM stays BUSY until real mem_ready.
- rst_n pulsed low during BUSY_DMA -> outputs return to reset values asynchronously. Post-release, starve_cnt=0: with both reqs high, CPU wins 4 before DMA.
